midi_bus_arbiter: RTL and testbench

MIDI_BUS_ARBITER -- requirements
Module: midi_bus_arbiter

---
 rtl/midi_pkg.sv | 29 ++
 rtl/midi_bus_arbiter_if.sv | 27 ++
 rtl/rr_pick.sv | 34 +++
 rtl/midi_bus_arbiter.sv | 93 +++++++++
 tb/tb_midi_bus_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/midi_pkg.sv
// Shared types and default sizes for the MIDI serial-channel bus arbiter.
package midi_pkg;

  localparam int MIDI_NCH = 4;
  localparam int MIDI_DW  = 8;
  localparam int MIDI_CW  = $clog2(MIDI_NCH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    WRITE   = 2'd3
  } midi_state_t;

  // Downstream FIFO word: source channel in the upper bits, byte below.
  typedef struct packed {
    logic [MIDI_CW-1:0] chan;
    logic [MIDI_DW-1:0] data;
  } fifo_word_t;

  function automatic fifo_word_t make_word(input logic [MIDI_CW-1:0] chan,
                                           input logic [MIDI_DW-1:0] data);
    fifo_word_t w;
    w.chan = chan;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/midi_bus_arbiter_if.sv
// Channel-side and FIFO-side signals of the arbiter; master = arbiter, slave = environment.
interface midi_bus_arbiter_if #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = $clog2(NCH)
);
  logic [NCH-1:0]   irq;
  logic [NCH-1:0]   ch_en;
  logic             rr_mode;
  logic [NCH-1:0]   bus_rd;
  logic [CW-1:0]    addr;
  logic [DW-1:0]    bus_data;
  logic             fifo_full;
  logic             fifo_wr;
  logic [CW+DW-1:0] fifo_data;
  logic             busy;

  modport master (
    input  irq, ch_en, rr_mode, bus_data, fifo_full,
    output bus_rd, addr, fifo_wr, fifo_data, busy
  );

  modport slave (
    output irq, ch_en, rr_mode, bus_data, fifo_full,
    input  bus_rd, addr, fifo_wr, fifo_data, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational grant picker: lowest set request (fixed) or first set request after ptr (round robin).
module rr_pick
  import midi_pkg::*;
#(
  parameter int NCH = MIDI_NCH,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  input  logic           rr_mode,
  output logic [CW-1:0]  grant,
  output logic           valid
);

  int idx;

  // Both scans run from the far end so the nearest candidate is the last one written.
  always_comb begin
    grant = '0;
    valid = |req;
    idx   = 0;
    if (!rr_mode) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req[i]) grant = CW'(i);
      end
    end else begin
      for (int i = NCH; i >= 1; i--) begin
        idx = (int'(ptr) + i) % NCH;
        if (req[idx]) grant = CW'(idx);
      end
    end
  end

endmodule

// File: rtl/midi_bus_arbiter.sv
// Arbitrates NCH byte-available channels, reads one byte per grant and forwards {chan, byte} to a FIFO.
// One transfer in flight; a full FIFO stalls in WRITE with the word held.
module midi_bus_arbiter
  import midi_pkg::*;
#(
  parameter int NCH = MIDI_NCH,
  parameter int DW  = MIDI_DW,
  parameter int CW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  midi_bus_arbiter_if.master   bus
);

  midi_state_t       state;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     grant;
  logic [NCH-1:0]    rd_strobe;
  logic              wr_strobe;
  logic [CW+DW-1:0]  word;
  logic              busy_r;

  logic [NCH-1:0]    req;
  logic [CW-1:0]     pick;
  logic              pick_vld;

  assign req = bus.irq & bus.ch_en;

  rr_pick #(
    .NCH (NCH),
    .CW  (CW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .rr_mode (bus.rr_mode),
    .grant   (pick),
    .valid   (pick_vld)
  );

  // fifo_wr is registered: it is raised on the edge that enters (or stays in)
  // WRITE with room downstream, so it is high for the last WRITE cycle only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= CW'(NCH - 1);
      grant     <= '0;
      rd_strobe <= '0;
      wr_strobe <= 1'b0;
      word      <= '0;
      busy_r    <= 1'b0;
    end else begin
      rd_strobe <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant     <= pick;
            ptr       <= pick;
            rd_strobe <= NCH'(1) << pick;
            busy_r    <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          word      <= {grant, bus.bus_data};
          wr_strobe <= !bus.fifo_full;
          state     <= WRITE;
        end
        WRITE: begin
          if (wr_strobe) begin
            wr_strobe <= 1'b0;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end else if (!bus.fifo_full) begin
            wr_strobe <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bus_rd    = rd_strobe;
  assign bus.addr      = grant;
  assign bus.fifo_wr   = wr_strobe;
  assign bus.fifo_data = word;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_midi_bus_arbiter.sv
// Directed bench for midi_bus_arbiter: expected FIFO words go to a scoreboard queue when stimulus is driven.
module tb_midi_bus_arbiter;
  import midi_pkg::*;

  logic clk;
  logic reset_n;

  midi_bus_arbiter_if #(.NCH(4), .DW(8)) bus ();

  midi_bus_arbiter #(.NCH(4), .DW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         ch2_hits = 0;
  fifo_word_t sb[$];
  logic [7:0] chan_byte [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel model: byte appears on bus_data the cycle after its strobe.
  always @(posedge clk) begin
    if (bus.bus_rd != '0) bus.bus_data <= chan_byte[bus.addr];
    else                  bus.bus_data <= 8'h00;
  end

  // FIFO-side monitor and scoreboard.
  always @(negedge clk) begin
    if (bus.bus_rd[2]) ch2_hits++;
    if (reset_n && bus.fifo_wr) begin
      if (sb.size() == 0) check("wr_with_empty_sb", 32'(sb.size()), 32'd1);
      else                check("fifo_data", 32'(bus.fifo_data), 32'(sb.pop_front()));
    end
  end

  task automatic wait_grant(input string tag, output int idx);
    idx = -1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.bus_rd != '0) begin
        idx = int'(bus.addr);
        break;
      end
    end
    check(tag, 32'(idx >= 0), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.busy && !bus.fifo_wr) begin
        seen = 1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  int g;
  int rr_order [6] = '{0, 1, 3, 0, 1, 3};
  logic [9:0] held;

  initial begin
    for (int i = 0; i < 4; i++) chan_byte[i] = 8'hA0 + 8'(i);
    bus.bus_data  = 8'h00;
    bus.irq       = 4'hF;
    bus.ch_en     = 4'hF;
    bus.rr_mode   = 1'b0;
    bus.fifo_full = 1'b0;
    reset_n       = 1'b0;

    // Reset state with requests pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_rd", 32'(bus.bus_rd), 32'h0);
    check("rst_fifo_wr", 32'(bus.fifo_wr), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_addr", 32'(bus.addr), 32'h0);
    check("rst_fifo_data", 32'(bus.fifo_data), 32'h0);
    sb.push_back(make_word(2'd0, chan_byte[0]));
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_bus_rd", 32'(bus.bus_rd), 32'b0001);
    bus.irq = 4'h0;
    wait_idle("idle_after_first");

    // Single channel, fixed priority, latency
    chan_byte[2] = 8'h90;
    sb.push_back(make_word(2'd2, 8'h90));
    bus.irq = 4'b0100;
    @(negedge clk);
    check("single_bus_rd", 32'(bus.bus_rd), 32'b0100);
    check("single_addr", 32'(bus.addr), 32'd2);
    check("single_busy", 32'(bus.busy), 32'd1);
    bus.irq = 4'b0000;
    @(negedge clk);
    check("read_one_cycle", 32'(bus.bus_rd), 32'h0);
    check("addr_held", 32'(bus.addr), 32'd2);
    @(negedge clk);
    check("single_fifo_wr", 32'(bus.fifo_wr), 32'd1);
    wait_idle("idle_after_single");

    // Fixed priority with two requesters
    for (int t = 0; t < 3; t++) sb.push_back(make_word(2'd1, chan_byte[1]));
    bus.irq = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      wait_grant("fixed_grant_timeout", g);
      check("fixed_grant", 32'(g), 32'd1);
      check("fixed_bus_rd", 32'(bus.bus_rd), 32'b0010);
    end
    bus.irq = 4'b0000;
    wait_idle("idle_after_fixed");

    // Round robin from a fresh reset, channel 2 disabled
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ch2_hits = 0;
    bus.rr_mode = 1'b1;
    bus.ch_en   = 4'b1011;
    for (int t = 0; t < 6; t++) sb.push_back(make_word(2'(rr_order[t]), chan_byte[rr_order[t]]));
    bus.irq = 4'hF;
    for (int t = 0; t < 6; t++) begin
      wait_grant("rr_grant_timeout", g);
      check("rr_grant", 32'(g), 32'(rr_order[t]));
    end
    bus.irq = 4'h0;
    wait_idle("idle_after_rr");
    check("rr_ch2_never", 32'(ch2_hits), 32'd0);

    // Backpressure: FIFO full on entry to WRITE for 5 cycles
    bus.rr_mode = 1'b0;
    bus.ch_en   = 4'hF;
    chan_byte[0] = 8'h3C;
    sb.push_back(make_word(2'd0, 8'h3C));
    bus.irq = 4'b0001;
    @(negedge clk);
    check("bp_bus_rd", 32'(bus.bus_rd), 32'b0001);
    bus.irq = 4'hF;
    bus.fifo_full = 1'b1;
    @(posedge clk);
    @(posedge clk);
    held = 10'h0_3C;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_fifo_wr_low", 32'(bus.fifo_wr), 32'd0);
      check("bp_fifo_data", 32'(bus.fifo_data), 32'(held));
      check("bp_no_bus_rd", 32'(bus.bus_rd), 32'h0);
    end
    bus.fifo_full = 1'b0;
    bus.irq = 4'h0;
    @(negedge clk);
    check("bp_fifo_wr", 32'(bus.fifo_wr), 32'd1);
    wait_idle("idle_after_bp");

    // Reset while in CAPTURE abandons the byte and restarts the pointer
    bus.rr_mode = 1'b1;
    bus.irq = 4'b0100;
    @(negedge clk);
    check("mid_bus_rd", 32'(bus.bus_rd), 32'b0100);
    bus.irq = 4'h0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_fifo_wr", 32'(bus.fifo_wr), 32'd0);
    check("mid_rst_fifo_data", 32'(bus.fifo_data), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_no_wr", 32'(bus.fifo_wr), 32'd0);
    end
    sb.push_back(make_word(2'd0, chan_byte[0]));
    bus.irq = 4'hF;
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_rr_restart", 32'(bus.bus_rd), 32'b0001);
    bus.irq = 4'h0;
    wait_idle("idle_after_mid_rst");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
